// File: rtl/cq_viola_resetseq_pkg.sv
// Shared register map, bit positions and state encodings for the Nios II reset sequencer.
package cq_viola_resetseq_pkg;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_HOLD    = 2'd2;
    localparam logic [1:0] ADDR_TIMEOUT = 2'd3;

    localparam int CTRL_RUN_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int STAT_READY_BIT  = 3;
    localparam int STAT_FAULT_BIT  = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // A zero hold would never reach the count==1 exit, so it is treated as one cycle.
    function automatic logic [15:0] hold_load(input logic [15:0] hold);
        return (hold == 16'd0) ? 16'd1 : hold;
    endfunction

    function automatic logic holds_target(input state_t s);
        return (s == ST_IDLE) || (s == ST_HOLD) || (s == ST_FAULT);
    endfunction

endpackage

// File: rtl/cq_viola_sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module cq_viola_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cq_viola_nios2_resetseq.sv
// Avalon-MM controlled reset sequencer: holds the target core in reset, releases it,
// and watches its ready status with an optional start-up timeout.
//
// state | meaning
// IDLE  | target held in reset, waiting for RUN
// HOLD  | target held in reset for the HOLD count
// WAIT  | target released, waiting for ready (optional timeout)
// RUN   | target alive
// FAULT | timeout or ready lost; target held until FAULT is cleared
module cq_viola_nios2_resetseq
    import cq_viola_resetseq_pkg::*;
#(
    parameter logic [15:0] HOLD_DEFAULT    = 16'd16,
    parameter logic [15:0] TIMEOUT_DEFAULT = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        target_ready,
    output logic        target_reset,
    output logic        irq
);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        irq_en_q, irq_en_d;
    logic        fault_q, fault_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] tmo_q, tmo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        tgt_rst_q, tgt_rst_d;
    logic        irq_q, irq_d;

    logic ready_s;
    logic wr, wr_ctrl, wr_status, wr_hold, wr_tmo;
    logic unused_wdata;

    cq_viola_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (target_ready),
        .q_o   (ready_s)
    );

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == ADDR_CTRL);
    assign wr_status = wr && (address == ADDR_STATUS);
    assign wr_hold   = wr && (address == ADDR_HOLD);
    assign wr_tmo    = wr && (address == ADDR_TIMEOUT);
    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        irq_en_d = irq_en_q;
        fault_d  = fault_q;
        hold_d   = hold_q;
        tmo_d    = tmo_q;

        if (wr_ctrl) begin
            run_d    = writedata[CTRL_RUN_BIT];
            irq_en_d = writedata[CTRL_IRQ_EN_BIT];
        end
        if (wr_hold) hold_d = writedata[15:0];
        if (wr_tmo)  tmo_d  = writedata[15:0];

        case (state_q)
            ST_IDLE: begin
                if (wr_ctrl && writedata[CTRL_RUN_BIT]) begin
                    state_d = ST_HOLD;
                    cnt_d   = hold_load(hold_q);
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'd1) begin
                    state_d = ST_WAIT;
                    cnt_d   = tmo_q;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_WAIT: begin
                // A zero load parks the counter at 0, which is what disables the timeout.
                if (ready_s) begin
                    state_d = ST_RUN;
                end else if (cnt_q == 16'd1) begin
                    state_d = ST_FAULT;
                end else if (cnt_q != 16'd0) begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RUN: begin
                if (!ready_s) state_d = ST_FAULT;
            end
            ST_FAULT: begin
                if (wr_status && writedata[STAT_FAULT_BIT]) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Software stop wins over any same-cycle timeout or ready transition.
        if (wr_ctrl && !writedata[CTRL_RUN_BIT] &&
            (state_q == ST_HOLD || state_q == ST_WAIT || state_q == ST_RUN)) begin
            state_d = ST_IDLE;
        end

        if (state_d == ST_FAULT && state_q != ST_FAULT) begin
            fault_d = 1'b1;
            run_d   = 1'b0;
        end
    end

    assign tgt_rst_d = holds_target(state_d);
    assign irq_d     = fault_d && irq_en_d;

    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_CTRL: begin
                rdata_d[CTRL_RUN_BIT]    = run_q;
                rdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            ADDR_STATUS: begin
                rdata_d[2:0]            = state_q;
                rdata_d[STAT_READY_BIT] = ready_s;
                rdata_d[STAT_FAULT_BIT] = fault_q;
            end
            ADDR_HOLD:    rdata_d[15:0] = hold_q;
            ADDR_TIMEOUT: rdata_d[15:0] = tmo_q;
            default:      rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'd0;
            run_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            fault_q   <= 1'b0;
            hold_q    <= HOLD_DEFAULT;
            tmo_q     <= TIMEOUT_DEFAULT;
            rdata_q   <= 32'd0;
            tgt_rst_q <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            irq_en_q  <= irq_en_d;
            fault_q   <= fault_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            rdata_q   <= rdata_d;
            tgt_rst_q <= tgt_rst_d;
            irq_q     <= irq_d;
        end
    end

    assign readdata     = rdata_q;
    assign target_reset = tgt_rst_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_cq_viola_nios2_resetseq.sv
// Self-checking bench for the reset sequencer: register reads go through a scoreboard queue.
module tb_cq_viola_nios2_resetseq;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        target_ready;
    logic        target_reset;
    logic        irq;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    cq_viola_nios2_resetseq dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .target_ready (target_ready),
        .target_reset (target_reset),
        .irq          (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] e);
        exp_t item;
        @(negedge clk);
        address = a;
        sb_q.push_back('{tag, e});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            item = sb_q.pop_front();
            chk(item.tag, readdata, item.exp);
        end
    endtask

    initial begin
        reset        = 1'b1;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'd0;
        target_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_rdata", readdata, 32'd0);
        chk("rst_treset", {31'd0, target_reset}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;

        rd("rst_ctrl", 2'd0, 32'h0);
        rd("rst_hold", 2'd2, 32'd16);
        rd("rst_tmo", 2'd3, 32'd1024);
        rd("rst_status", 2'd1, 32'h08);

        // Normal start with ready already high, HOLD=4
        wr(2'd2, 32'd4);
        wr(2'd0, 32'h1);
        chk("seq_tr_e0", {31'd0, target_reset}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("seq_tr_e%0d", i), {31'd0, target_reset}, 32'd1);
        end
        @(negedge clk);
        chk("seq_tr_e4", {31'd0, target_reset}, 32'd0);
        rd("seq_run_status", 2'd1, 32'h0B);

        // Timeout with IRQ_EN=1
        wr(2'd0, 32'h0);
        target_ready = 1'b0;
        wr(2'd3, 32'd8);
        wr(2'd0, 32'h3);
        repeat (4) @(negedge clk);
        chk("tmo_tr_wait_entry", {31'd0, target_reset}, 32'd0);
        repeat (7) @(negedge clk);
        chk("tmo_tr_before", {31'd0, target_reset}, 32'd0);
        @(negedge clk);
        chk("tmo_tr_fault", {31'd0, target_reset}, 32'd1);
        chk("tmo_irq_en", {31'd0, irq}, 32'd1);
        rd("tmo_status", 2'd1, 32'h14);
        rd("tmo_ctrl_run_cleared", 2'd0, 32'h2);
        wr(2'd1, 32'h10);
        chk("tmo_irq_cleared", {31'd0, irq}, 32'd0);
        rd("tmo_status_cleared", 2'd1, 32'h00);

        // Timeout with IRQ_EN=0; writes without bit4 leave FAULT
        wr(2'd0, 32'h1);
        repeat (14) @(negedge clk);
        chk("tmo2_irq_dis", {31'd0, irq}, 32'd0);
        chk("tmo2_tr", {31'd0, target_reset}, 32'd1);
        rd("tmo2_status", 2'd1, 32'h14);
        wr(2'd1, 32'h0F);
        wr(2'd0, 32'h1);
        rd("tmo2_sticky", 2'd1, 32'h14);
        wr(2'd1, 32'h10);
        rd("tmo2_cleared", 2'd1, 32'h00);

        // Ready lost while running
        target_ready = 1'b1;
        wr(2'd0, 32'h3);
        repeat (8) @(negedge clk);
        rd("run_status", 2'd1, 32'h0B);
        wr(2'd0, 32'h3);
        rd("run_no_restart", 2'd1, 32'h0B);
        @(negedge clk);
        target_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_tr", {31'd0, target_reset}, 32'd1);
        chk("drop_irq", {31'd0, irq}, 32'd1);
        rd("drop_status", 2'd1, 32'h14);
        wr(2'd1, 32'h10);
        chk("drop_irq_cleared", {31'd0, irq}, 32'd0);
        rd("drop_status_cleared", 2'd1, 32'h00);
        rd("drop_ctrl", 2'd0, 32'h2);

        // Stop in WAIT on the same edge ready_s rises
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h1);
        repeat (10) @(negedge clk);
        rd("prio_wait", 2'd1, 32'h02);
        @(negedge clk);
        target_ready = 1'b1;
        @(negedge clk);
        wr(2'd0, 32'h0);
        chk("prio_tr", {31'd0, target_reset}, 32'd1);
        rd("prio_status", 2'd1, 32'h08);

        // TIMEOUT=0 never faults; HOLD=0 acts as one cycle
        target_ready = 1'b0;
        wr(2'd2, 32'd0);
        wr(2'd0, 32'h1);
        chk("hold0_tr_e0", {31'd0, target_reset}, 32'd1);
        @(negedge clk);
        chk("hold0_tr_e1", {31'd0, target_reset}, 32'd0);
        repeat (5000) @(negedge clk);
        rd("notmo_status", 2'd1, 32'h02);
        chk("notmo_tr", {31'd0, target_reset}, 32'd0);
        wr(2'd0, 32'h0);

        // Asynchronous reset during WAIT
        wr(2'd2, 32'd7);
        wr(2'd0, 32'h3);
        repeat (10) @(negedge clk);
        rd("arst_wait", 2'd1, 32'h02);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_tr", {31'd0, target_reset}, 32'd1);
        chk("arst_rdata", readdata, 32'd0);
        chk("arst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rd("arst_ctrl", 2'd0, 32'h0);
        rd("arst_hold", 2'd2, 32'd16);
        rd("arst_tmo", 2'd3, 32'd1024);
        rd("arst_status", 2'd1, 32'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cq_viola_nios2_resetseq.md
CQ_VIOLA_NIOS2_RESETSEQ -- requirements
Module: cq_viola_nios2_resetseq

Interface
REQ-001 Parameter HOLD_DEFAULT, 16, reset value of HOLD register (cycles target held in reset).
REQ-002 Parameter TIMEOUT_DEFAULT, 1024, reset value of TIMEOUT register (cycles allowed for target_ready).
REQ-003 clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 address  in  2  Avalon-MM slave word address.
REQ-006 chipselect  in  1  slave select.
REQ-007 write_n  in  1  active-low write strobe.
REQ-008 writedata  in  32  write data.
REQ-009 readdata  out  32  registered read data.
REQ-010 target_ready  in  1  asynchronous "target alive" status from the sequenced core.
REQ-011 target_reset  out  1  active-high reset to the sequenced core.
REQ-012 irq  out  1  level interrupt, fault indication.

Function
REQ-013 Register map: 0 CTRL (bit0 RUN, bit1 IRQ_EN); 1 STATUS (bits[2:0] state, bit3 ready_s, bit4 FAULT); 2 HOLD [15:0]; 3 TIMEOUT [15:0]; unused bits read 0.
REQ-014 Write occurs when chipselect=1 and write_n=0; SHALL take effect on that clock edge.
REQ-015 readdata SHALL be registered every cycle from the address mux: read latency 1 cycle, no wait states.
REQ-016 target_ready SHALL pass a 2-flop synchronizer; ready_s is its output; all decisions use ready_s.
REQ-017 States and encodings: IDLE=0, HOLD=1, WAIT=2, RUN=3, FAULT=4.
REQ-018 target_reset SHALL be 1 in IDLE, HOLD, FAULT and 0 in WAIT, RUN, registered from state.
REQ-019 IDLE -> HOLD when CTRL write sets RUN=1; 16-bit counter loads max(HOLD,1).
REQ-020 HOLD: counter decrements each cycle; on counter==1 -> WAIT, counter loads TIMEOUT.
REQ-021 WAIT: ready_s=1 -> RUN; else if TIMEOUT!=0 and counter==1 -> FAULT; else decrement; TIMEOUT=0 disables timeout.
REQ-022 RUN: ready_s falling to 0 -> FAULT.
REQ-023 Entering FAULT SHALL set sticky FAULT bit and clear RUN.
REQ-024 FAULT -> IDLE only by STATUS write with bit4=1 (clears FAULT); other writes leave FAULT.
REQ-025 CTRL write with RUN=0 in HOLD, WAIT or RUN -> IDLE next cycle; this SHALL take priority over any same-cycle transition (including timeout and ready).
REQ-026 CTRL write with RUN=1 while not IDLE SHALL not restart the sequence.
REQ-027 HOLD/TIMEOUT writes SHALL not affect an in-progress count; used at next load only.
REQ-028 irq = FAULT & IRQ_EN, registered.

Reset
REQ-029 On reset: state=IDLE, target_reset=1, CTRL=0, FAULT=0, HOLD=HOLD_DEFAULT, TIMEOUT=TIMEOUT_DEFAULT, counter=0, synchronizer=0, readdata=0, irq=0.
REQ-030 Reset asserted mid-sequence SHALL force IDLE and target_reset=1 asynchronously.

Structure
REQ-031 Register addresses, bit positions and state encodings SHALL live in shared package cq_viola_resetseq_pkg.
REQ-032 The 2-flop synchronizer SHALL be a sub-module cq_viola_sync2; everything else flat.

Verification
REQ-033 Reset, HOLD=4, write CTRL=1, ready held 1 -> target_reset low exactly 4 cycles after write edge, RUN within 2 more cycles, STATUS reads 3.
REQ-034 TIMEOUT=8, ready=0, start -> FAULT 8 cycles after WAIT entry, STATUS=0x14, target_reset=1; irq=1 only if IRQ_EN=1.
REQ-035 In RUN, drop ready -> FAULT within 3 cycles; write STATUS=0x10 -> IDLE, FAULT=0, irq=0.
REQ-036 In WAIT, write CTRL=0 same cycle ready_s rises -> IDLE, target_reset=1.
REQ-037 TIMEOUT=0, ready=0 for 5000 cycles -> remains WAIT; HOLD=0 -> behaves as HOLD=1.
REQ-038 Assert reset during WAIT -> target_reset=1 immediately, registers return to defaults.
